// File: rtl/mux_scan_nx1.sv
// rtl/mux_scan_nx1.sv - NUM_CH:1 registered mux with DIRECT select and one-shot SCAN sweep
// Output word is loaded only when the register is empty or being accepted.
module mux_scan_nx1 #(
  parameter int WIDTH  = 1,
  parameter int NUM_CH = 16,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    start,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0]  data_d;
  logic [SEL_W-1:0]  ch_d;
  logic              valid_d, err_d, done_d;
  logic [WIDTH-1:0]  sel_word, ptr_word;
  logic              mask_bit, slot;

  // Compare indices at SEL_W+1 bits so out-of-range selects match no channel.
  always_comb begin
    sel_word = '0;
    ptr_word = '0;
    mask_bit = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if ({1'b0, sel} == k[SEL_W:0])
        sel_word = in[k*WIDTH +: WIDTH];
      if ({1'b0, ptr_q} == k[SEL_W:0]) begin
        ptr_word = in[k*WIDTH +: WIDTH];
        mask_bit = mask_q[k];
      end
    end
  end

  assign slot = !out_valid | out_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    data_d  = out_data;
    ch_d    = out_ch;
    valid_d = out_valid;
    err_d   = sel_err;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mode) begin
          if (slot) begin
            ch_d    = sel;
            valid_d = 1'b1;
            if ({1'b0, sel} < NUM_CH_W) begin
              data_d = sel_word;
              err_d  = 1'b0;
            end else begin
              data_d = '0;
              err_d  = 1'b1;
            end
          end
        end else begin
          if (slot) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
          end
          if (start) begin
            mask_d  = ch_en;
            ptr_d   = '0;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (slot) begin
          err_d = 1'b0;
          if (mask_bit) begin
            data_d  = ptr_word;
            ch_d    = ptr_q;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
          if (ptr_q == LAST_CH) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      mask_q    <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      mask_q    <= mask_d;
      out_data  <= data_d;
      out_ch    <= ch_d;
      out_valid <= valid_d;
      sel_err   <= err_d;
      done      <= done_d;
    end
  end

  assign busy = (state_q == SCAN);

endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb/tb_mux_scan_nx1.sv - directed bench for mux_scan_nx1 (DIRECT table plus SCAN sequences)
module tb_mux_scan_nx1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u1: WIDTH=1 NUM_CH=16
  logic [15:0] in1;  logic [3:0] sel1; logic mode1; logic [15:0] en1; logic start1;
  logic od1; logic [3:0] oc1; logic ov1, rdy1, err1, busy1, done1;
  // u2: WIDTH=1 NUM_CH=10
  logic [9:0] in2;   logic [3:0] sel2; logic mode2; logic [9:0] en2; logic start2;
  logic od2; logic [3:0] oc2; logic ov2, rdy2, err2, busy2, done2;
  // u3: WIDTH=8 NUM_CH=16
  logic [127:0] in3; logic [3:0] sel3; logic mode3; logic [15:0] en3; logic start3;
  logic [7:0] od3; logic [3:0] oc3; logic ov3, rdy3, err3, busy3, done3;

  mux_scan_nx1 #(.WIDTH(1), .NUM_CH(16)) u1 (
    .clk(clk), .rst(rst), .in(in1), .sel(sel1), .mode(mode1), .ch_en(en1), .start(start1),
    .out_data(od1), .out_ch(oc1), .out_valid(ov1), .out_ready(rdy1), .sel_err(err1),
    .busy(busy1), .done(done1));
  mux_scan_nx1 #(.WIDTH(1), .NUM_CH(10)) u2 (
    .clk(clk), .rst(rst), .in(in2), .sel(sel2), .mode(mode2), .ch_en(en2), .start(start2),
    .out_data(od2), .out_ch(oc2), .out_valid(ov2), .out_ready(rdy2), .sel_err(err2),
    .busy(busy2), .done(done2));
  mux_scan_nx1 #(.WIDTH(8), .NUM_CH(16)) u3 (
    .clk(clk), .rst(rst), .in(in3), .sel(sel3), .mode(mode3), .ch_en(en3), .start(start3),
    .out_data(od3), .out_ch(oc3), .out_valid(ov3), .out_ready(rdy3), .sel_err(err3),
    .busy(busy3), .done(done3));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       which;   // 0 = u1 (16 ch), 1 = u2 (10 ch)
    logic [3:0] sel;
    logic       exp_data;
    logic       exp_err;
  } dvec_t;

  dvec_t dv[10];

  int          wch[$];
  logic [7:0]  wdat[$];

  task automatic run_scan(input string tag, input logic [15:0] en, input int stall_n);
    int done_cyc, busy_cyc, ndone, stall_left, nexp;
    done_cyc = 0; busy_cyc = 0; ndone = 0; stall_left = stall_n; nexp = 0;
    wch.delete(); wdat.delete();
    @(negedge clk);
    en3 = en; start3 = 1'b1; rdy3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    if (busy3) busy_cyc++;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      rdy3 = !(stall_left > 0 && ov3 && oc3 == 4'd2);
      if (!rdy3) stall_left--;
      if (ov3 && rdy3) begin
        wch.push_back(int'(oc3));
        wdat.push_back(od3);
      end
      @(posedge clk); #1;
      if (!rdy3) check({tag, " stall hold"}, {ov3, od3}, {1'b1, 8'h12});
      if (busy3) busy_cyc++;
      if (done3) begin
        ndone++;
        if (done_cyc == 0) done_cyc = i;
      end
      if (done_cyc != 0 && i >= done_cyc + 2) break;
    end
    rdy3 = 1'b1;
    check({tag, " done cycle"}, done_cyc, 16 + stall_n);
    check({tag, " done count"}, ndone, 1);
    check({tag, " busy cycles"}, busy_cyc, 16 + stall_n);
    for (int k = 0; k < 16; k++) if (en[k]) nexp++;
    check({tag, " word count"}, wch.size(), nexp);
    begin
      int j = 0;
      for (int k = 0; k < 16; k++) begin
        if (en[k] && j < wch.size()) begin
          check({tag, " word ch"}, wch[j], k);
          check({tag, " word data"}, wdat[j], 8'h10 + k[7:0]);
          j++;
        end
      end
    end
  endtask

  initial begin
    dv[0] = '{1'b0, 4'h3, 1'b1, 1'b0};
    dv[1] = '{1'b0, 4'ha, 1'b0, 1'b0};
    dv[2] = '{1'b0, 4'h6, 1'b1, 1'b0};
    dv[3] = '{1'b0, 4'hc, 1'b1, 1'b0};
    dv[4] = '{1'b1, 4'hc, 1'b0, 1'b1};
    dv[5] = '{1'b1, 4'h9, 1'b1, 1'b0};
    dv[6] = '{1'b1, 4'h8, 1'b0, 1'b0};
    dv[7] = '{1'b1, 4'ha, 1'b0, 1'b1};
    dv[8] = '{1'b1, 4'hf, 1'b0, 1'b1};
    dv[9] = '{1'b1, 4'h0, 1'b1, 1'b0};

    rst = 1'b1;
    in1 = 16'h33ff; sel1 = 4'h0; mode1 = 1'b0; en1 = '0; start1 = 1'b0; rdy1 = 1'b1;
    in2 = 10'h2b5;  sel2 = 4'h0; mode2 = 1'b0; en2 = '0; start2 = 1'b0; rdy2 = 1'b1;
    sel3 = 4'h0; mode3 = 1'b1; en3 = '0; start3 = 1'b0; rdy3 = 1'b1;
    for (int k = 0; k < 16; k++) in3[k*8 +: 8] = 8'h10 + k[7:0];

    repeat (2) @(posedge clk);
    #1;
    check("reset u1", {od1, oc1, ov1, err1, busy1, done1}, 32'h0);
    check("reset u2", {od2, oc2, ov2, err2, busy2, done2}, 32'h0);
    check("reset u3", {od3, oc3, ov3, err3, busy3, done3}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dv[i].which) sel2 = dv[i].sel; else sel1 = dv[i].sel;
      @(posedge clk); #1;
      if (dv[i].which)
        check($sformatf("direct10 sel=%0h", dv[i].sel), {od2, err2, oc2, ov2},
              {dv[i].exp_data, dv[i].exp_err, dv[i].sel, 1'b1});
      else
        check($sformatf("direct16 sel=%0h", dv[i].sel), {od1, err1, oc1, ov1},
              {dv[i].exp_data, dv[i].exp_err, dv[i].sel, 1'b1});
    end

    check("scan idle no valid", {ov3, busy3}, 2'b00);
    run_scan("scan8005", 16'h8005, 0);
    run_scan("stall8005", 16'h8005, 3);
    run_scan("scan0", 16'h0000, 0);

    // Reset five cycles into a full sweep must abort without a done pulse.
    @(negedge clk);
    en3 = 16'hffff; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre-reset busy", busy3, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid-scan reset", {od3, oc3, ov3, err3, busy3, done3}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int nd = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (done3 || busy3) nd++;
      end
      check("no done after reset", nd, 0);
    end
    run_scan("rescan", 16'hffff, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
